// File: rtl/logic_fold_unit.sv
// Registered bitwise operator (AND/OR/XOR/NAND) with per-sample pass mode and
// DEPTH-sample fold mode, valid/ready on both sides, single-entry output register.
module logic_fold_unit #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       op,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    out_count
);

   typedef enum logic {S_IDLE, S_ACCUM} state_t;

   localparam logic [CW-1:0] LP_LAST  = CW'(DEPTH - 1);
   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] LP_ONE   = CW'(1);

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_op;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [CW-1:0]    r_out_count;

   logic [1:0]       w_op_eff;
   logic [WIDTH-1:0] w_s;
   logic [WIDTH-1:0] w_fold;
   logic             w_stall;
   logic             w_accept;

   always_comb begin
      w_op_eff = (r_state == S_ACCUM) ? r_op : op;
      w_s      = '0;
      case (w_op_eff)
         2'b00:   w_s = in_a & in_b;
         2'b01:   w_s = in_a | in_b;
         2'b10:   w_s = in_a ^ in_b;
         default: w_s = ~(in_a & in_b);
      endcase
      w_fold = '0;
      case (r_op)
         2'b01:   w_fold = r_acc | w_s;
         2'b10:   w_fold = r_acc ^ w_s;
         default: w_fold = r_acc & w_s;
      endcase
   end

   // mode may not reach in_ready combinationally, so any IDLE accept is
   // treated as result-producing and is held off under backpressure.
   always_comb begin
      w_stall  = r_out_valid && !out_ready;
      in_ready = !rst && !(w_stall && ((r_state == S_IDLE) || (r_cnt == LP_LAST)));
      w_accept = in_valid && in_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_op        <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_count <= '0;
      end else begin
         if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            if (r_state == S_IDLE) begin
               if (!mode) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_s;
                  r_out_count <= LP_ONE;
               end else begin
                  r_acc   <= w_s;
                  r_cnt   <= LP_ONE;
                  r_op    <= op;
                  r_state <= S_ACCUM;
               end
            end else if (r_cnt == LP_LAST) begin
               r_out_valid <= 1'b1;
               r_out_data  <= w_fold;
               r_out_count <= LP_DEPTH;
               r_acc       <= '0;
               r_cnt       <= '0;
               r_state     <= S_IDLE;
            end else begin
               r_acc <= w_fold;
               r_cnt <= r_cnt + LP_ONE;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_count = r_out_count;

endmodule

// File: tb/tb_logic_fold_unit.sv
// Bench for logic_fold_unit: directed scenarios plus random traffic, all
// checked against a frame-list reference model.
module tb_logic_fold_unit;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic [1:0]       op = '0;
   logic             mode = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    out_count;

   logic_fold_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .op(op), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_count(out_count)
   );

   always #5 clk = ~clk;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   // reference model: pending result plus list of per-sample values of the open frame
   logic [WIDTH-1:0] frame[$];
   logic [1:0]       frame_op = '0;
   logic             exp_valid = 1'b0;
   logic [WIDTH-1:0] exp_data = '0;
   int unsigned      exp_count = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      case (o)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] fold_frame(input logic [1:0] o);
      logic [WIDTH-1:0] r;
      r = frame[0];
      for (int i = 1; i < frame.size(); i++) begin
         if (o == 2'b01)      r = r | frame[i];
         else if (o == 2'b10) r = r ^ frame[i];
         else                 r = r & frame[i];
      end
      return r;
   endfunction

   // a result-producing accept (pass, or last of frame) needs room in the output register;
   // with no open frame the sample may be a pass sample, so it waits too
   function automatic logic model_ready();
      if (rst) return 1'b0;
      if (exp_valid && !out_ready && (frame.size() == 0 || frame.size() == DEPTH - 1)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] o, input logic m, input logic ordy);
      logic rdy;
      in_valid = v; in_a = a; in_b = b; op = o; mode = m; out_ready = ordy;
      #1;
      rdy = model_ready();
      chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      @(posedge clk);
      if (rst) begin
         frame.delete();
         exp_valid = 1'b0; exp_data = '0; exp_count = 0;
      end else begin
         if (exp_valid && ordy) exp_valid = 1'b0;
         if (v && rdy) begin
            if (frame.size() == 0 && !m) begin
               exp_valid = 1'b1; exp_data = apply_op(o, a, b); exp_count = 1;
            end else begin
               if (frame.size() == 0) frame_op = o;
               frame.push_back(apply_op(frame_op, a, b));
               if (frame.size() == DEPTH) begin
                  exp_valid = 1'b1; exp_data = fold_frame(frame_op); exp_count = DEPTH;
                  frame.delete();
               end
            end
         end
      end
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      if (exp_valid || rst) begin
         chk("out_data", 32'(out_data), 32'(exp_data));
         chk("out_count", 32'(out_count), exp_count);
      end
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, '0, '0, 2'b00, 1'b0, ordy);
   endtask

   initial begin
      @(posedge clk); #1;

      rst = 1'b1;
      idle(1'b1);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      rst = 1'b0;
      idle(1'b1);
      chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

      step(1'b1, 8'hF0, 8'h3C, 2'b00, 1'b0, 1'b1);
      chk("pass_and", 32'(out_data), 32'h30);
      chk("pass_and_cnt", 32'(out_count), 32'd1);
      idle(1'b1);

      step(1'b1, 8'h01, 8'h00, 2'b10, 1'b1, 1'b1);
      step(1'b1, 8'h02, 8'h00, 2'b10, 1'b1, 1'b1);
      step(1'b1, 8'h04, 8'h00, 2'b10, 1'b1, 1'b1);
      chk("xor_early", {31'd0, out_valid}, 32'd0);
      step(1'b1, 8'h08, 8'h00, 2'b10, 1'b1, 1'b1);
      chk("xor_frame", 32'(out_data), 32'h0F);
      chk("xor_frame_cnt", 32'(out_count), 32'd4);
      idle(1'b1);

      step(1'b1, 8'hFF, 8'h0F, 2'b11, 1'b1, 1'b1);
      step(1'b1, 8'hFF, 8'hF0, 2'b01, 1'b0, 1'b1);
      step(1'b1, 8'hFF, 8'h00, 2'b01, 1'b0, 1'b1);
      step(1'b1, 8'hFF, 8'hFF, 2'b01, 1'b0, 1'b1);
      chk("nand_frame_v", {31'd0, out_valid}, 32'd1);
      chk("nand_frame", 32'(out_data), 32'h00);
      idle(1'b1);

      step(1'b1, 8'hAA, 8'h0F, 2'b00, 1'b0, 1'b0);
      step(1'b1, 8'h55, 8'h0F, 2'b00, 1'b0, 1'b0);
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_data", 32'(out_data), 32'h0A);
      step(1'b1, 8'h55, 8'h0F, 2'b00, 1'b0, 1'b1);
      chk("bp_second", 32'(out_data), 32'h05);
      idle(1'b1);

      step(1'b1, 8'hFF, 8'h00, 2'b00, 1'b1, 1'b1);
      step(1'b1, 8'hFF, 8'h00, 2'b00, 1'b1, 1'b1);
      rst = 1'b1;
      idle(1'b1);
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_count", 32'(out_count), 32'd0);
      rst = 1'b0;
      step(1'b1, 8'h01, 8'h00, 2'b01, 1'b1, 1'b1);
      step(1'b1, 8'h02, 8'h00, 2'b01, 1'b1, 1'b1);
      step(1'b1, 8'h04, 8'h00, 2'b01, 1'b1, 1'b1);
      step(1'b1, 8'h08, 8'h00, 2'b01, 1'b1, 1'b1);
      chk("rst_or_frame", 32'(out_data), 32'h0F);
      idle(1'b1);

      step(1'b1, 8'h11, 8'h00, 2'b01, 1'b0, 1'b1);
      chk("b2b_1", 32'(out_data), 32'h11);
      step(1'b1, 8'h22, 8'h00, 2'b01, 1'b0, 1'b1);
      chk("b2b_2", 32'(out_data), 32'h22);
      step(1'b1, 8'h33, 8'h00, 2'b01, 1'b0, 1'b1);
      chk("b2b_3", 32'(out_data), 32'h33);
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);

      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         step($urandom_range(0, 3) != 0, WIDTH'($urandom), WIDTH'($urandom),
              2'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 2) != 0);
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
